// File: rtl/cpu_pkg.sv
// Shared encodings and default bus widths for the CPU core, its memory arbiter and the memory.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_t;

    // Saturating increment used by the loader anti-starvation counter.
    function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] lim);
        logic [3:0] res;
        if (val >= lim) begin
            res = lim;
        end else begin
            res = val + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and loader memory ports.
module mem_arb_pick
    import cpu_pkg::*;
(
    input  logic   i_cpu_req,
    input  logic   i_ld_req,
    input  logic   i_ld_lock,
    input  logic   i_wait_full,
    output logic   o_grant_valid,
    output owner_t o_grant_owner
);

    // Priority: lock, starvation override, CPU, loader.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_owner = OWN_CPU;
        if (i_ld_lock) begin
            o_grant_valid = i_ld_req;
            o_grant_owner = OWN_LD;
        end else if (i_ld_req && i_wait_full) begin
            o_grant_valid = 1'b1;
            o_grant_owner = OWN_LD;
        end else if (i_cpu_req) begin
            o_grant_valid = 1'b1;
            o_grant_owner = OWN_CPU;
        end else if (i_ld_req) begin
            o_grant_valid = 1'b1;
            o_grant_owner = OWN_LD;
        end else begin
            o_grant_valid = 1'b0;
            o_grant_owner = OWN_CPU;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port memory between the CPU port and the loader/debug port,
// one transaction at a time: grant, memory strobe, read latency wait, ack.
module mem_bus_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MEM_LAT  = 1,
    parameter int WAIT_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              ld_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);
    localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

    arb_state_t        r_state;
    owner_t            r_owner;
    logic [2:0]        r_lat_cnt;
    logic [3:0]        r_wait_cnt;
    logic              r_cpu_ack;
    logic              r_ld_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ld_rdata;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_grant_valid;
    owner_t            w_grant_owner;
    logic              w_wait_full;

    assign w_wait_full = (r_wait_cnt == WAIT_LIM);

    mem_arb_pick u_pick (
        .i_cpu_req     (cpu_req),
        .i_ld_req      (ld_req),
        .i_ld_lock     (ld_lock),
        .i_wait_full   (w_wait_full),
        .o_grant_valid (w_grant_valid),
        .o_grant_owner (w_grant_owner)
    );

    // Transaction sequencer: grant latch, memory strobe, latency count, capture and ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ARB_IDLE;
            r_owner     <= OWN_CPU;
            r_lat_cnt   <= 3'd0;
            r_wait_cnt  <= 4'd0;
            r_cpu_ack   <= 1'b0;
            r_ld_ack    <= 1'b0;
            r_cpu_rdata <= '0;
            r_ld_rdata  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_cpu_ack <= 1'b0;
                    r_ld_ack  <= 1'b0;
                    if (w_grant_valid) begin
                        r_state  <= ARB_ISSUE;
                        r_owner  <= w_grant_owner;
                        r_mem_en <= 1'b1;
                        if (w_grant_owner == OWN_LD) begin
                            r_mem_we    <= ld_we;
                            r_mem_addr  <= ld_addr;
                            r_mem_wdata <= ld_wdata;
                            r_wait_cnt  <= 4'd0;
                        end else begin
                            r_mem_we    <= cpu_we;
                            r_mem_addr  <= cpu_addr;
                            r_mem_wdata <= cpu_wdata;
                            if (ld_req) begin
                                r_wait_cnt <= sat_inc4(r_wait_cnt, WAIT_LIM);
                            end else begin
                                r_wait_cnt <= r_wait_cnt;
                            end
                        end
                    end else begin
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_ISSUE: begin
                    r_mem_en  <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_lat_cnt <= LAT_INIT;
                    // r_mem_we still holds the latched direction of this transaction.
                    if (r_mem_we) begin
                        r_state <= ARB_RESP;
                        if (r_owner == OWN_LD) begin
                            r_ld_ack <= 1'b1;
                        end else begin
                            r_cpu_ack <= 1'b1;
                        end
                    end else begin
                        r_state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (r_lat_cnt <= 3'd1) begin
                        r_lat_cnt <= 3'd0;
                        r_state   <= ARB_RESP;
                        if (r_owner == OWN_LD) begin
                            r_ld_rdata <= mem_rdata;
                            r_ld_ack   <= 1'b1;
                        end else begin
                            r_cpu_rdata <= mem_rdata;
                            r_cpu_ack   <= 1'b1;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 3'd1;
                    end
                end
                ARB_RESP: begin
                    r_cpu_ack <= 1'b0;
                    r_ld_ack  <= 1'b0;
                    r_state   <= ARB_IDLE;
                end
                default: begin
                    r_state   <= ARB_IDLE;
                    r_mem_en  <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_cpu_ack <= 1'b0;
                    r_ld_ack  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign ld_ack    = r_ld_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign ld_rdata  = r_ld_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign owner     = r_owner;
    assign busy      = (r_state != ARB_IDLE);
    // Stall must follow the live request, so it is the only output with a combinational input term.
    assign cpu_stall = cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected acks, monitors pop and compare.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        ld_req, ld_we, ld_ack, ld_lock;
    logic [7:0]  ld_addr;
    logic [15:0] ld_wdata, ld_rdata;
    logic        mem_en, mem_we, owner, busy;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    logic        b_cpu_ack, b_cpu_stall, b_ld_req, b_ld_ack, b_mem_en, b_mem_we, b_owner, b_busy;
    logic [7:0]  b_ld_addr, b_mem_addr, cyc_lo;
    logic [15:0] b_cpu_rdata, b_ld_rdata, b_mem_wdata, b_mem_rdata;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int n_mem_en = 0;
    int n_cpu_ack = 0;
    int stall_bad = 0;
    bit in_lock = 1'b0;

    typedef struct {
        logic        port;
        logic        is_read;
        logic [15:0] rdata;
        int          at;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];

    logic [15:0] mem [256];

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(1), .WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata), .ld_lock(ld_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(3), .WAIT_MAX(4)) dut_lat3 (
        .clk(clk), .rst(rst),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(8'h00), .cpu_wdata(16'h0000),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
        .ld_req(b_ld_req), .ld_we(1'b0), .ld_addr(b_ld_addr), .ld_wdata(16'h0000),
        .ld_ack(b_ld_ack), .ld_rdata(b_ld_rdata), .ld_lock(1'b0),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .owner(b_owner), .busy(b_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Memory for the latency-3 instance returns a cycle-stamped pattern.
    assign cyc_lo      = cyc[7:0];
    assign b_mem_rdata = {8'hC0, cyc_lo};

    // Latency-1 memory model; data is only valid in the single cycle after a read strobe.
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        else mem_rdata <= 16'hDEAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Event counters and lock-mode stall watch.
    always @(negedge clk) begin
        if (mem_en) n_mem_en++;
        if (cpu_ack) n_cpu_ack++;
        if (in_lock && !cpu_stall) stall_bad++;
    end

    // Scoreboard monitor for the latency-1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && (cpu_ack || ld_ack)) begin
            if (q1.size() == 0) begin
                check("unexpected_ack", 32'({cpu_ack, ld_ack}), 32'd0);
            end else begin
                e = q1.pop_front();
                check("ack_both", 32'(cpu_ack & ld_ack), 32'd0);
                check("ack_port", 32'(ld_ack), 32'(e.port));
                check("ack_owner", 32'(owner), 32'(e.port));
                check("ack_cycle", 32'(cyc), 32'(e.at));
                if (e.is_read) check("ack_rdata", 32'(e.port ? ld_rdata : cpu_rdata), 32'(e.rdata));
            end
        end
    end

    // Scoreboard monitor for the latency-3 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && (b_cpu_ack || b_ld_ack)) begin
            if (q2.size() == 0) begin
                check("lat3_unexpected_ack", 32'({b_cpu_ack, b_ld_ack}), 32'd0);
            end else begin
                e = q2.pop_front();
                check("lat3_ack_port", 32'(b_ld_ack), 32'(e.port));
                check("lat3_ack_cycle", 32'(cyc), 32'(e.at));
                check("lat3_rdata", 32'(b_ld_rdata), 32'(e.rdata));
            end
        end
    end

    task automatic wait_ack(input logic port);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (port ? ld_ack : cpu_ack) seen = 1'b1;
        end
        if (port) ld_req = 1'b0;
        else cpu_req = 1'b0;
        check("ack_timeout", 32'(seen), 32'd1);
    endtask

    task automatic txn(input logic port, input logic we, input logic [7:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd);
        exp_t e;
        @(posedge clk); #1;
        if (port) begin
            ld_we = we; ld_addr = a; ld_wdata = d; ld_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        end
        e.port = port; e.is_read = !we; e.rdata = exp_rd;
        e.at = cyc + (we ? 2 : 3);
        q1.push_back(e);
        wait_ack(port);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
        check({tag, "_ld_ack"}, 32'(ld_ack), 32'd0);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_owner"}, 32'(owner), 32'd0);
        check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
        check({tag, "_ld_rdata"}, 32'(ld_rdata), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, a0, base;
        exp_t e;
        logic [7:0] t;
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 8'h00; ld_wdata = 16'h0000; ld_lock = 1'b0;
        b_ld_req = 1'b0; b_ld_addr = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        check("reset_lat3_busy", 32'(b_busy), 32'd0);
        @(posedge clk); #1; rst = 1'b1;

        // 1: CPU write then read of 0x12.
        n0 = n_mem_en;
        txn(1'b0, 1'b1, 8'h12, 16'hBEEF, 16'h0000);
        check("t1_wr_mem_en", 32'(n_mem_en - n0), 32'd1);
        n0 = n_mem_en;
        txn(1'b0, 1'b0, 8'h12, 16'h0000, 16'hBEEF);
        check("t1_rd_mem_en", 32'(n_mem_en - n0), 32'd1);

        // 2: both ports held: CPU x4 then loader, repeating.
        n0 = n_mem_en;
        @(posedge clk); #1;
        base = cyc;
        cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 16'h1111;
        ld_we = 1'b1; ld_addr = 8'h30; ld_wdata = 16'h2222;
        cpu_req = 1'b1; ld_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            e.port = (k % 5 == 4); e.is_read = 1'b0; e.rdata = 16'h0000; e.at = base + 2 + 3 * k;
            q1.push_back(e);
        end
        while (cyc < base + 29) @(negedge clk);
        cpu_req = 1'b0; ld_req = 1'b0;
        check("t2_mem_en", 32'(n_mem_en - n0), 32'd10);

        // 3: loader lock with CPU requesting continuously.
        n0 = n_mem_en; a0 = n_cpu_ack;
        @(posedge clk); #1;
        ld_lock = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 16'h9999; cpu_req = 1'b1;
        in_lock = 1'b1;
        for (int i = 0; i < 16; i++) txn(1'b1, 1'b1, 8'(i), 16'h5A00 + 16'(i), 16'h0000);
        @(negedge clk);
        in_lock = 1'b0; cpu_req = 1'b0;
        @(posedge clk); #1; ld_lock = 1'b0;
        check("t3_stall_low_cycles", 32'(stall_bad), 32'd0);
        check("t3_cpu_acks", 32'(n_cpu_ack - a0), 32'd0);
        check("t3_mem_en", 32'(n_mem_en - n0), 32'd16);
        txn(1'b1, 1'b0, 8'h0F, 16'h0000, 16'h5A0F);

        // 6: CPU read, request dropped and address changed during ISSUE.
        n0 = n_mem_en; a0 = n_cpu_ack;
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 8'h12; cpu_req = 1'b1;
        e.port = 1'b0; e.is_read = 1'b1; e.rdata = 16'hBEEF; e.at = cyc + 3;
        q1.push_back(e);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_addr = 8'h00;
        repeat (6) @(negedge clk);
        check("t6_mem_en", 32'(n_mem_en - n0), 32'd1);
        check("t6_cpu_acks", 32'(n_cpu_ack - a0), 32'd1);

        // 5: async reset during WAIT of a CPU read.
        a0 = n_cpu_ack;
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 8'h12; cpu_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5_in_wait_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy_now", 32'(busy), 32'd0);
        check("t5_mem_en_now", 32'(mem_en), 32'd0);
        @(negedge clk);
        check_reset_state("t5_next");
        cpu_req = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        check("t5_no_ack", 32'(n_cpu_ack - a0), 32'd0);
        txn(1'b0, 1'b0, 8'h12, 16'h0000, 16'hBEEF);

        // 4: latency-3 instance, loader read.
        @(posedge clk); #1;
        b_ld_addr = 8'h05; b_ld_req = 1'b1;
        t = 8'(cyc + 4);
        e.port = 1'b1; e.is_read = 1'b1; e.rdata = {8'hC0, t}; e.at = cyc + 5;
        q2.push_back(e);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (b_ld_ack) seen = 1'b1;
            end
            b_ld_req = 1'b0;
            check("t4_ack_timeout", 32'(seen), 32'd1);
        end

        repeat (4) @(negedge clk);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
